vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
- Display-side end of the pixel interface used by the game renderers such as the enemy-plane judge.
- Generates the 640x480@60 scan, drives pixel coordinates x/y out to every renderer, and samples the renderers' returned rgb.
- Emits pixel-aligned VGA sync and colour pins.
- Emits the frame-rate movement tick that paces object motion.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz clk gives a 25 MHz pixel rate).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- MOVE_DIV, 2, frames per move tick (must be 1 or more).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- x  out  10  current pixel column (h_cnt); valid as a coordinate only when video_on=1.
- y  out  10  current pixel row (v_cnt); valid only when video_on=1.
- video_on  out  1  1 when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- rgb  in  12  colour returned combinationally by the renderers for the current x/y.
- pix_en  out  1  one-clk strobe every CLK_DIV clocks; the counters advance on this strobe.
- vga_hs  out  1  horizontal sync, active-low, registered.
- vga_vs  out  1  vertical sync, active-low, registered.
- vga_rgb  out  12  registered colour; 0 during blanking.
- frame_tick  out  1  one-clk pulse at the start of vertical blanking.
- move_tick  out  1  one-clk pulse on every MOVE_DIV-th frame_tick.

Behaviour:
- Totals: H_TOT = 800 and V_TOT = 525 with the default parameters (sum of the four segments each).
- Reset (rst=0, async): all counters are 0, pix_en=0, vga_hs=1, vga_vs=1, vga_rgb=0, frame_tick=0, move_tick=0.
- Pixel divider:
  - div_cnt counts 0..CLK_DIV-1.
  - pix_en=1 in the clk where div_cnt==CLK_DIV-1.
  - The first pix_en occurs CLK_DIV clocks after reset release.
- On a pix_en clock:
  - h_cnt wraps H_TOT-1 -> 0; on that wrap, v_cnt increments.
  - v_cnt wraps V_TOT-1 -> 0 on the clock where both counters wrap.
- x/y equal h_cnt/v_cnt directly, so renderers see the new coordinate immediately after each pix_en edge.
- Output alignment, registered on the same pix_en edge that advances the counters:
  - vga_rgb <= video_on ? rgb : 0.
  - vga_hs <= ~(H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC).
  - vga_vs <= ~(V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC).
  - All pin outputs therefore lag x/y by exactly one pixel, consistently.
- frame_tick:
  - 1 for exactly one clk, the clk after the pix_en edge on which (h_cnt,v_cnt) becomes (0,V_ACTIVE).
  - One pulse per frame.
- move_tick:
  - frame counter f_cnt runs 0..MOVE_DIV-1 and increments on each frame_tick.
  - move_tick=1 in the same clk as the frame_tick on which f_cnt==MOVE_DIV-1; f_cnt then wraps to 0.
  - With MOVE_DIV=1, move_tick equals frame_tick.
- Boundaries:
  - Colour is blanked on the first blank pixel: at h_cnt=H_ACTIVE the registered vga_rgb is 0 on the next pix_en.
  - rgb is ignored whenever video_on=0.
  - Reset asserted mid-frame returns everything to the reset values immediately.
  - After reset, the scan restarts at (0,0) and f_cnt restarts at 0.
  - No output toggles between pix_en strobes, except frame_tick and move_tick falling.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_/V_ segments and totals);
  - the colour width (12);
  - the coordinate width (10).
- Renderers import the same package.
- One natural sub-module, vga_timing_cnt: the divider plus the h/v counters, producing pix_en, h_cnt, v_cnt and video_on.
- The top level adds the sync/rgb output registers and the frame/move tick logic.

Test Plan:
1. Release reset, run 2 clk with rgb=12'hFFF -> pix_en first high at clk 2; x=0, y=0, video_on=1; vga_rgb=12'hFFF after the next pix_en.
2. Count clocks between vga_hs falling edges -> exactly 1600 clk (800 px * 2); low width 192 clk; first fall one pixel after h_cnt reaches 656.
3. Full frame -> vga_vs low for 2 lines (3200 clk), starting one pixel after v_cnt reaches 490; 525 lines per frame.
4. Drive rgb=12'hF00 constantly -> vga_rgb=12'hF00 during active pixels, and 0 at every blanked pixel (first 0 one pixel after x=640).
5. Run 5 frames with MOVE_DIV=2 -> 5 frame_tick pulses 840000 clk apart, each 1 clk wide; move_tick on the 2nd and 4th only.
6. Assert rst=0 at x=300, y=200 for 3 clk, then release -> outputs return to reset values immediately; scan resumes at (0,0); first frame_tick 768000 clk later (480 lines * 1600 clk).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and bus widths for the scan controller and the renderers.
package vga_pkg;

  localparam int unsigned COLOR_W  = 12;
  localparam int unsigned COORD_W  = 10;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/vga_timing_cnt.sv
// Pixel-rate divider plus horizontal/vertical scan counters.
module vga_timing_cnt
  import vga_pkg::COORD_W;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned H_TOT    = vga_pkg::H_TOT,
  parameter int unsigned V_TOT    = vga_pkg::V_TOT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] h_cnt,
  output logic [COORD_W-1:0] v_cnt,
  output logic               video_on
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);

  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_nxt;
  logic [COORD_W-1:0] h_nxt;
  logic [COORD_W-1:0] v_nxt;

  // Next-state of divider and scan position; counters only move on a pix_en clock.
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    h_nxt   = h_cnt;
    v_nxt   = v_cnt;
    if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_nxt = h_cnt + 1'b1;
      end
    end
  end

  // pix_en is registered from the next divider value so it is high while div_cnt==CLK_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      pix_en   <= 1'b0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      video_on <= 1'b1;
    end else begin
      div_cnt  <= div_nxt;
      pix_en   <= (div_nxt == DIV_LAST);
      h_cnt    <= h_nxt;
      v_cnt    <= v_nxt;
      video_on <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: drives x/y to the renderers, registers sync/colour pins one pixel
// behind the coordinates, and paces object motion with frame and move ticks.
module vga_scan_ctrl
  import vga_pkg::COORD_W;
  import vga_pkg::COLOR_W;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned MOVE_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               video_on,
  input  logic [COLOR_W-1:0] rgb,
  output logic               pix_en,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [COLOR_W-1:0] vga_rgb,
  output logic               frame_tick,
  output logic               move_tick
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned F_W   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_PRE  = COORD_W'(V_ACTIVE - 1);
  localparam logic [F_W-1:0]     F_LAST = F_W'(MOVE_DIV - 1);

  logic           frame_start;
  logic [F_W-1:0] f_cnt;

  vga_timing_cnt #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_TOT    (H_TOT),
    .V_TOT    (V_TOT)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .h_cnt    (x),
    .v_cnt    (y),
    .video_on (video_on)
  );

  // The pix_en edge that moves the scan from the last visible line into vertical blanking.
  assign frame_start = pix_en && (x == H_LAST) && (y == V_PRE);

  // Pin outputs sample the current pixel on the same edge that advances the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
      vga_rgb <= '0;
    end else if (pix_en) begin
      vga_rgb <= video_on ? rgb : '0;
      vga_hs  <= !((x >= HS_BEG) && (x < HS_END));
      vga_vs  <= !((y >= VS_BEG) && (y < VS_END));
    end
  end

  // Frame and move ticks; f_cnt divides frame_tick down to the motion rate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_tick <= 1'b0;
      move_tick  <= 1'b0;
      f_cnt      <= '0;
    end else begin
      frame_tick <= frame_start;
      move_tick  <= frame_start && (f_cnt == F_LAST);
      if (frame_start) begin
        f_cnt <= (f_cnt == F_LAST) ? '0 : f_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl using a shrunken raster so whole frames fit a short run.
module tb_vga_scan_ctrl;

  localparam int CLK_DIV  = 2;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int MOVE_DIV = 2;
  localparam int HT    = HA + HF + HS + HB;   // 15 pixels per line
  localparam int VT    = VA + VF + VS + VB;   // 13 lines per frame
  localparam int LINE  = HT * CLK_DIV;        // 30 clk
  localparam int FRAME = VT * LINE;           // 390 clk

  logic        clk;
  logic        rst;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic [11:0] rgb;
  logic        pix_en;
  logic        vga_hs;
  logic        vga_vs;
  logic [11:0] vga_rgb;
  logic        frame_tick;
  logic        move_tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  vga_scan_ctrl #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .MOVE_DIV(MOVE_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .rgb        (rgb),
    .pix_en     (pix_en),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_rgb    (vga_rgb),
    .frame_tick (frame_tick),
    .move_tick  (move_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Colour the renderers would return for the current coordinate.
  task automatic drive_rgb();
    rgb = (int'(x) < HA && int'(y) < VA) ? 12'hF00 : 12'h5A5;
  endtask

  // Wait for a falling edge on hs (sel=0) or vs (sel=1); returns the cycle stamp or -1.
  task automatic wait_fall(input int sel, output int t);
    logic p;
    p = sel ? vga_vs : vga_hs;
    t = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (p && !(sel ? vga_vs : vga_hs)) begin
        t = cyc;
        break;
      end
      p = sel ? vga_vs : vga_hs;
    end
    if (t < 0) check(sel ? "vs_fall_timeout" : "hs_fall_timeout", 32'd0, 32'd1);
  endtask

  // Cycles a sync pin stays low from its fall until it is seen high again.
  task automatic low_width(input int sel, output int w);
    w = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      w++;
      if (sel ? vga_vs : vga_hs) break;
    end
  endtask

  initial begin
    int t1, t2, w, n, t_last, nft;
    int rgb_bad, von_bad, stall_bad, wide_bad, stray_mt;
    logic [31:0] mt_mask;
    logic [9:0]  p_x, p_y;
    logic [11:0] p_rgb, exp_rgb;
    logic        p_hs, p_vs, p_pix, exp_von, prev_ft, found, done_blank, done_last;

    // 1: reset values, first pix_en, first colour sample
    rst = 1'b0;
    rgb = 12'hFFF;
    repeat (3) @(negedge clk);
    check("rst_pix_en", 32'(pix_en), 32'd0);
    check("rst_hs", 32'(vga_hs), 32'd1);
    check("rst_vs", 32'(vga_vs), 32'd1);
    check("rst_rgb", 32'(vga_rgb), 32'd0);
    check("rst_ticks", {30'd0, frame_tick, move_tick}, 32'd0);
    check("rst_xy", {6'd0, x, 6'd0, y}, 32'd0);
    rst = 1'b1;
    step();
    check("first_pix_en", 32'(pix_en), 32'd1);
    check("first_xy", {6'd0, x, 6'd0, y}, 32'd0);
    check("first_video_on", 32'(video_on), 32'd1);
    step();
    check("first_rgb", 32'(vga_rgb), 32'hFFF);
    check("first_x_adv", 32'(x), 32'd1);

    // 2: hsync position, period and width
    wait_fall(0, t1);
    check("hs_fall_x", 32'(x), 32'(HA + HF + 1));
    low_width(0, w);
    check("hs_low_width", 32'(w), 32'(HS * CLK_DIV));
    wait_fall(0, t2);
    check("hs_period", 32'(t2 - t1), 32'(LINE));

    // 3: vsync position, period and width
    wait_fall(1, t1);
    check("vs_fall_xy", {6'd0, x, 6'd0, y}, {6'd0, 10'd1, 6'd0, 10'(VA + VF)});
    low_width(1, w);
    check("vs_low_width", 32'(w), 32'(VS * LINE));
    wait_fall(1, t2);
    check("vs_period", 32'(t2 - t1), 32'(FRAME));

    // 4: colour pass-through/blanking and no pin activity between strobes, over one frame
    rgb_bad = 0; von_bad = 0; stall_bad = 0; done_blank = 0; done_last = 0;
    for (int i = 0; i < 2; i++) begin
      drive_rgb();
      step();
    end
    for (int i = 0; i < FRAME; i++) begin
      drive_rgb();
      p_x = x; p_y = y; p_hs = vga_hs; p_vs = vga_vs; p_rgb = vga_rgb; p_pix = pix_en;
      step();
      if (!p_pix && (x != p_x || y != p_y || vga_hs != p_hs || vga_vs != p_vs || vga_rgb != p_rgb))
        stall_bad++;
      exp_von = (int'(x) < HA) && (int'(y) < VA);
      if (video_on !== exp_von) von_bad++;
      exp_rgb = (x != 10'd0 && int'(x) <= HA && int'(y) < VA) ? 12'hF00 : 12'h000;
      if (vga_rgb !== exp_rgb) rgb_bad++;
      if (!done_last && int'(x) == HA && int'(y) < VA) begin
        check("rgb_last_active", 32'(vga_rgb), 32'hF00);
        done_last = 1;
      end
      if (!done_blank && int'(x) == HA + 1 && int'(y) < VA) begin
        check("rgb_first_blank", 32'(vga_rgb), 32'd0);
        done_blank = 1;
      end
    end
    check("rgb_frame_mismatches", 32'(rgb_bad), 32'd0);
    check("video_on_mismatches", 32'(von_bad), 32'd0);
    check("toggle_between_strobes", 32'(stall_bad), 32'd0);

    // 6: reset mid-frame, then restart latency to the first frame_tick
    rgb = 12'hF00;
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (x == 10'd5 && y == 10'd3) begin
        found = 1;
        break;
      end
      step();
    end
    check("found_5_3", 32'(found), 32'd1);
    check("rgb_before_reset", 32'(vga_rgb), 32'hF00);
    rst = 1'b0;
    #1;
    check("midrst_xy", {6'd0, x, 6'd0, y}, 32'd0);
    check("midrst_pins", {28'd0, pix_en, vga_hs, vga_vs, frame_tick}, 32'b0110);
    check("midrst_rgb", 32'(vga_rgb), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_hold", {6'd0, x, 4'd0, pix_en, vga_rgb}, 32'd0);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n++;
      if (frame_tick) break;
    end
    check("ft_after_reset_clk", 32'(n), 32'(VA * LINE));
    check("ft_xy", {6'd0, x, 6'd0, y}, {16'd0, 6'd0, 10'(VA)});

    // 5: five frame ticks, one clk wide, a frame apart; move_tick on the 2nd and 4th
    t_last = cyc; nft = 1; wide_bad = 0; stray_mt = 0; prev_ft = 1'b1;
    mt_mask = move_tick ? 32'd1 : 32'd0;
    for (int i = 0; i < 4 * FRAME + 10; i++) begin
      step();
      if (frame_tick) begin
        if (prev_ft) begin
          wide_bad++;
        end else begin
          check($sformatf("ft_gap%0d", nft), 32'(cyc - t_last), 32'(FRAME));
          t_last = cyc;
          if (move_tick && nft < 32) mt_mask = mt_mask | (32'd1 << nft);
          nft++;
        end
      end else if (move_tick) begin
        stray_mt++;
      end
      prev_ft = frame_tick;
    end
    check("ft_count", 32'(nft), 32'd5);
    check("ft_wide", 32'(wide_bad), 32'd0);
    check("mt_pattern", mt_mask, 32'b01010);
    check("mt_outside_ft", 32'(stray_mt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
